// File: rtl/sprite_anim_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sprite_anim_pkg
// Shared types and defaults for the sprite animation sequencer.
//   state_t      : sequencer FSM state (IDLE, WALK, HIT)
//   DEF_*        : default parameter values for the top module
//   cnt_w()      : width of a down-counter that must hold n-1 (never below 1)
// -----------------------------------------------------------------------------
package sprite_anim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_HIT  = 2'd2
    } state_t;

    localparam int DEF_NUM_FRAMES   = 4;
    localparam int DEF_FRAME_W      = 2;
    localparam int DEF_FRAME_PERIOD = 6;
    localparam int DEF_BLINK_FRAMES = 24;
    localparam int DEF_BLINK_PERIOD = 4;

    // $clog2(1) is 0, which would give a zero-width counter; clamp to 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sprite_anim_sequencer_if.sv
// -----------------------------------------------------------------------------
// sprite_anim_sequencer_if
// Bundles the game-logic side of the sprite animation sequencer.
//   Inputs to the sequencer : startOfFrame, moveLeft, moveRight, hit, freeze
//   Outputs of the sequencer: flipX, frameIdx, visible, hitActive, state
// Handshake: there is no valid/ready pair. startOfFrame is a one-cycle
// qualifier pulse with no backpressure; hit is a one-cycle event that the
// sequencer always accepts (it is latched until the next unfrozen frame
// start); move*/freeze are levels; all outputs are registered levels that
// hold for a whole video frame. state is a debug view of the FSM.
// -----------------------------------------------------------------------------
interface sprite_anim_sequencer_if #(
    parameter int FRAME_W = sprite_anim_pkg::DEF_FRAME_W
);
    logic                   startOfFrame;
    logic                   moveLeft;
    logic                   moveRight;
    logic                   hit;
    logic                   freeze;
    logic                   flipX;
    logic [FRAME_W-1:0]     frameIdx;
    logic                   visible;
    logic                   hitActive;
    sprite_anim_pkg::state_t state;

    // Game logic / bench side.
    modport master (
        output startOfFrame, moveLeft, moveRight, hit, freeze,
        input  flipX, frameIdx, visible, hitActive, state
    );

    // Sequencer side.
    modport slave (
        input  startOfFrame, moveLeft, moveRight, hit, freeze,
        output flipX, frameIdx, visible, hitActive, state
    );
endinterface

// File: rtl/sprite_anim_sequencer_frame_tick_counter.sv
// -----------------------------------------------------------------------------
// frame_tick_counter
// Loadable down-counter advanced once per unfrozen video frame.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   load       : count <= RELOAD (has priority over tick)
//   tick       : decrement by one, saturating at zero
//   zero       : count == 0
// -----------------------------------------------------------------------------
module frame_tick_counter #(
    parameter int              WIDTH  = 3,
    parameter logic [WIDTH-1:0] RELOAD = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sprite_anim_sequencer.sv
// -----------------------------------------------------------------------------
// sprite_anim_sequencer
// Per-sprite animation controller. Once per unfrozen video frame it decides
// facing direction (flipX), steps the walk-cycle frame index and runs the
// hit-blink sequence that gates visibility. All decisions happen on the
// frame-start edge so a frame is never drawn half-mirrored.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of sprite_anim_sequencer_if (inputs startOfFrame,
//           moveLeft, moveRight, hit, freeze; registered outputs flipX,
//           frameIdx, visible, hitActive, debug state)
// -----------------------------------------------------------------------------
module sprite_anim_sequencer
    import sprite_anim_pkg::*;
#(
    parameter int NUM_FRAMES   = DEF_NUM_FRAMES,
    parameter int FRAME_W      = DEF_FRAME_W,
    parameter int FRAME_PERIOD = DEF_FRAME_PERIOD,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int BLINK_PERIOD = DEF_BLINK_PERIOD
) (
    input  logic                  clk,
    input  logic                  reset,
    sprite_anim_sequencer_if.slave bus
);

    localparam int WALK_W  = cnt_w(FRAME_PERIOD);
    localparam int BLINK_W = cnt_w(BLINK_FRAMES);
    localparam int PHASE_W = cnt_w(BLINK_PERIOD);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

    state_t state, state_next;
    logic   hit_latch;

    logic   sof;
    logic   moving;
    logic   hit_pend;

    logic   walk_load, walk_tick, walk_zero;
    logic   blink_load, blink_tick, blink_zero;
    logic   phase_load, phase_tick, phase_zero;

    logic               flip_next;
    logic [FRAME_W-1:0] frame_next;
    logic               visible_next;
    logic               hit_active_next;

    // Freeze masks the frame start entirely; only the hit latch keeps working.
    assign sof    = bus.startOfFrame & ~bus.freeze;
    assign moving = bus.moveLeft ^ bus.moveRight;
    // A hit arriving on the same edge as the frame start is consumed there.
    assign hit_pend = hit_latch | bus.hit;

    // ---------------------------------------------------------------- counters
    frame_tick_counter #(
        .WIDTH (WALK_W),
        .RELOAD(WALK_W'(FRAME_PERIOD - 1))
    ) u_walk_cnt (
        .clk  (clk),
        .reset(reset),
        .load (walk_load),
        .tick (walk_tick),
        .zero (walk_zero)
    );

    frame_tick_counter #(
        .WIDTH (BLINK_W),
        .RELOAD(BLINK_W'(BLINK_FRAMES - 1))
    ) u_blink_cnt (
        .clk  (clk),
        .reset(reset),
        .load (blink_load),
        .tick (blink_tick),
        .zero (blink_zero)
    );

    frame_tick_counter #(
        .WIDTH (PHASE_W),
        .RELOAD(PHASE_W'(BLINK_PERIOD - 1))
    ) u_phase_cnt (
        .clk  (clk),
        .reset(reset),
        .load (phase_load),
        .tick (phase_tick),
        .zero (phase_zero)
    );

    // ------------------------------------------------------ state register
    // Also holds the hit latch and the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            hit_latch     <= 1'b0;
            bus.flipX     <= 1'b0;
            bus.frameIdx  <= '0;
            bus.visible   <= 1'b1;
            bus.hitActive <= 1'b0;
        end else begin
            state         <= state_next;
            bus.flipX     <= flip_next;
            bus.frameIdx  <= frame_next;
            bus.visible   <= visible_next;
            bus.hitActive <= hit_active_next;
            if (sof) begin
                hit_latch <= 1'b0;
            end else if (bus.hit) begin
                hit_latch <= 1'b1;
            end
        end
    end

    assign bus.state = state;

    // ---------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        if (sof) begin
            unique case (state)
                ST_IDLE: begin
                    if (hit_pend) begin
                        state_next = ST_HIT;
                    end else if (moving) begin
                        state_next = ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (hit_pend) begin
                        state_next = ST_HIT;
                    end else if (!moving) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_HIT: begin
                    if (hit_pend) begin
                        state_next = ST_HIT;
                    end else if (blink_zero) begin
                        state_next = moving ? ST_WALK : ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------- outputs and counters
    always_comb begin
        walk_load       = 1'b0;
        walk_tick       = 1'b0;
        blink_load      = 1'b0;
        blink_tick      = 1'b0;
        phase_load      = 1'b0;
        phase_tick      = 1'b0;
        flip_next       = bus.flipX;
        frame_next      = bus.frameIdx;
        visible_next    = bus.visible;
        hit_active_next = bus.hitActive;

        if (sof) begin
            // Facing direction is frozen while blinking.
            if (state != ST_HIT) begin
                if (bus.moveLeft && !bus.moveRight) begin
                    flip_next = 1'b1;
                end else if (bus.moveRight && !bus.moveLeft) begin
                    flip_next = 1'b0;
                end
            end

            if (hit_pend) begin
                // Entry into HIT from any state, including a full restart.
                blink_load      = 1'b1;
                phase_load      = 1'b1;
                visible_next    = 1'b0;
                hit_active_next = 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        frame_next = '0;
                        if (moving) begin
                            walk_load = 1'b1;
                        end
                    end
                    ST_WALK: begin
                        if (!moving) begin
                            frame_next = '0;
                        end else if (walk_zero) begin
                            frame_next = (bus.frameIdx == LAST_FRAME) ? '0
                                                                      : bus.frameIdx + 1'b1;
                            walk_load  = 1'b1;
                        end else begin
                            walk_tick = 1'b1;
                        end
                    end
                    ST_HIT: begin
                        if (blink_zero) begin
                            visible_next    = 1'b1;
                            hit_active_next = 1'b0;
                            if (moving) begin
                                walk_load = 1'b1;
                            end else begin
                                frame_next = '0;
                            end
                        end else begin
                            blink_tick = 1'b1;
                            if (phase_zero) begin
                                visible_next = ~bus.visible;
                                phase_load   = 1'b1;
                            end else begin
                                phase_tick = 1'b1;
                            end
                        end
                    end
                    default: frame_next = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sprite_anim_sequencer
// Directed bench for sprite_anim_sequencer with default parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// that follows the rising edge under test.
// -----------------------------------------------------------------------------
module tb_sprite_anim_sequencer;
    import sprite_anim_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    sprite_anim_sequencer_if #(.FRAME_W(2)) bus ();

    sprite_anim_sequencer #(
        .NUM_FRAMES  (4),
        .FRAME_W     (2),
        .FRAME_PERIOD(6),
        .BLINK_FRAMES(24),
        .BLINK_PERIOD(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // ------------------------------------------------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------- check helper
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------- driver tasks
    task automatic sof_step();
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
    endtask

    task automatic sof_hit_step();
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        bus.hit          = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        bus.hit          = 1'b0;
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin
        errors           = 0;
        checks           = 0;
        reset            = 1'b1;
        bus.startOfFrame = 1'b0;
        bus.moveLeft     = 1'b0;
        bus.moveRight    = 1'b0;
        bus.hit          = 1'b0;
        bus.freeze       = 1'b0;

        // Reset values.
        idle_cycles(3);
        chk("rst_flip", int'(bus.flipX), 0);
        chk("rst_frame", int'(bus.frameIdx), 0);
        chk("rst_visible", int'(bus.visible), 1);
        chk("rst_hit_active", int'(bus.hitActive), 0);
        chk("rst_state", int'(bus.state), int'(ST_IDLE));
        reset = 1'b0;
        idle_cycles(2);

        // Walk to the right for 25 frames: steps on SOFs 7, 13, 19, 25.
        bus.moveRight = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            sof_step();
            chk($sformatf("walk_frame_sof%0d", k), int'(bus.frameIdx), ((k - 1) / 6) % 4);
            chk($sformatf("walk_flip_sof%0d", k), int'(bus.flipX), 0);
        end
        chk("walk_state", int'(bus.state), int'(ST_WALK));

        // moveLeft between frame starts must not flip.
        bus.moveRight = 1'b0;
        bus.moveLeft  = 1'b1;
        idle_cycles(3);
        chk("dir_no_sof_flip", int'(bus.flipX), 0);
        bus.moveLeft = 1'b0;
        sof_step();
        chk("dir_neither_flip", int'(bus.flipX), 0);
        chk("dir_neither_state", int'(bus.state), int'(ST_IDLE));
        chk("dir_neither_frame", int'(bus.frameIdx), 0);
        bus.moveLeft = 1'b1;
        sof_step();
        chk("dir_left_flip", int'(bus.flipX), 1);
        chk("dir_left_state", int'(bus.state), int'(ST_WALK));
        bus.moveRight = 1'b1;
        sof_step();
        chk("dir_both_flip", int'(bus.flipX), 1);
        chk("dir_both_state", int'(bus.state), int'(ST_IDLE));
        bus.moveLeft = 1'b0;
        sof_step();
        chk("dir_right_flip", int'(bus.flipX), 0);
        chk("dir_right_state", int'(bus.state), int'(ST_WALK));
        repeat (5) sof_step();
        chk("walk2_before_step", int'(bus.frameIdx), 0);
        sof_step();
        chk("walk2_step", int'(bus.frameIdx), 1);

        // Mid-frame hit while walking: latched, acted on at the next SOF.
        hit_pulse();
        idle_cycles(2);
        chk("hit_wait_active", int'(bus.hitActive), 0);
        chk("hit_wait_visible", int'(bus.visible), 1);
        sof_step();
        chk("hit_entry_active", int'(bus.hitActive), 1);
        chk("hit_entry_visible", int'(bus.visible), 0);
        chk("hit_entry_frame", int'(bus.frameIdx), 1);
        chk("hit_entry_state", int'(bus.state), int'(ST_HIT));
        // Direction request during blink must be ignored.
        bus.moveRight = 1'b0;
        bus.moveLeft  = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            sof_step();
            chk($sformatf("blink_visible_p%0d", k), int'(bus.visible), (k / 4) % 2);
            chk($sformatf("blink_active_p%0d", k), int'(bus.hitActive), 1);
            chk($sformatf("blink_flip_p%0d", k), int'(bus.flipX), 0);
        end
        sof_step();
        chk("blink_exit_visible", int'(bus.visible), 1);
        chk("blink_exit_active", int'(bus.hitActive), 0);
        chk("blink_exit_state", int'(bus.state), int'(ST_WALK));
        chk("blink_exit_frame", int'(bus.frameIdx), 1);
        chk("blink_exit_flip", int'(bus.flipX), 0);
        sof_step();
        chk("post_blink_flip", int'(bus.flipX), 1);

        // Hit coincident with SOF, then a second hit at +10 restarts.
        sof_hit_step();
        chk("rs_entry_active", int'(bus.hitActive), 1);
        chk("rs_entry_visible", int'(bus.visible), 0);
        for (int k = 1; k <= 9; k++) begin
            sof_step();
            chk($sformatf("rs_pre_visible_p%0d", k), int'(bus.visible), (k / 4) % 2);
            chk($sformatf("rs_pre_state_p%0d", k), int'(bus.state), int'(ST_HIT));
        end
        sof_hit_step();
        chk("rs_restart_visible", int'(bus.visible), 0);
        chk("rs_restart_active", int'(bus.hitActive), 1);
        for (int k = 1; k <= 23; k++) begin
            sof_step();
            chk($sformatf("rs_visible_p%0d", k), int'(bus.visible), (k / 4) % 2);
            chk($sformatf("rs_active_p%0d", k), int'(bus.hitActive), 1);
        end
        sof_step();
        chk("rs_exit_active", int'(bus.hitActive), 0);
        chk("rs_exit_visible", int'(bus.visible), 1);
        chk("rs_exit_state", int'(bus.state), int'(ST_WALK));
        chk("rs_exit_frame", int'(bus.frameIdx), 1);

        // Freeze for 10 frames with a hit and a direction change inside.
        bus.freeze    = 1'b1;
        bus.moveLeft  = 1'b0;
        bus.moveRight = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) hit_pulse();
            sof_step();
            chk($sformatf("frz_flip_%0d", i), int'(bus.flipX), 1);
            chk($sformatf("frz_frame_%0d", i), int'(bus.frameIdx), 1);
            chk($sformatf("frz_active_%0d", i), int'(bus.hitActive), 0);
            chk($sformatf("frz_state_%0d", i), int'(bus.state), int'(ST_WALK));
        end
        bus.freeze    = 1'b0;
        bus.moveRight = 1'b0;
        bus.moveLeft  = 1'b1;
        sof_step();
        chk("unfrz_active", int'(bus.hitActive), 1);
        chk("unfrz_visible", int'(bus.visible), 0);
        chk("unfrz_state", int'(bus.state), int'(ST_HIT));
        chk("unfrz_frame", int'(bus.frameIdx), 1);

        // Asynchronous reset mid-HIT with a hit still latched.
        sof_step();
        sof_step();
        hit_pulse();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_visible", int'(bus.visible), 1);
        chk("arst_active", int'(bus.hitActive), 0);
        chk("arst_frame", int'(bus.frameIdx), 0);
        chk("arst_flip", int'(bus.flipX), 0);
        chk("arst_state", int'(bus.state), int'(ST_IDLE));
        @(negedge clk);
        reset        = 1'b0;
        bus.moveLeft = 1'b0;
        sof_step();
        chk("arst_latch_state", int'(bus.state), int'(ST_IDLE));
        chk("arst_latch_active", int'(bus.hitActive), 0);

        // ------------------------------------------------------- report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_anim_sequencer.md
# sprite_anim_sequencer

Per-sprite animation controller that sequences the bitmap mirroring and frame-select datapath. Once per video frame it decides facing direction (the mirror-enable for the horizontal offset flip), steps a walk-cycle frame index, and runs a hit-blink sequence that gates sprite visibility. Sits between game logic (movement/hit events) and the sprite bitmap address path; all decisions are taken on `startOfFrame` so a frame is never drawn half-mirrored.

## Interface
- `NUM_FRAMES`, 4: walk-cycle length; frame index wraps modulo this.
- `FRAME_W`, 2: width of `frameIdx` (holds `NUM_FRAMES-1`).
- `FRAME_PERIOD`, 6: video frames per walk step (≥1).
- `BLINK_FRAMES`, 24: video frames spent in hit-blink (≥1).
- `BLINK_PERIOD`, 4: video frames per visibility toggle during blink (≥1).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `moveLeft` in 1: level, sprite moving left.
- `moveRight` in 1: level, sprite moving right.
- `hit` in 1: one-cycle event pulse, any cycle.
- `freeze` in 1: level, game paused; blocks all frame-rate updates.
- `flipX` out 1: 1 = mirror horizontally (facing left).
- `frameIdx` out FRAME_W: walk-cycle bitmap select.
- `visible` out 1: 1 = sprite drawn.
- `hitActive` out 1: 1 while in blink sequence.

## Operation
- Reset values: `flipX`=0, `frameIdx`=0, `visible`=1, `hitActive`=0, state IDLE, hit latch clear, all counters 0.
- "SOF" below = clock edge with `startOfFrame`=1 and `freeze`=0. No state, counter or output changes on any other edge except the hit latch.
- Hit latch: set on any edge with `hit`=1; cleared on the SOF that consumes it. `hit` coincident with an SOF is consumed on that SOF. During `freeze` the latch holds.
- Direction (`moving` = `moveLeft` XOR `moveRight`): on SOF outside HIT, `moveLeft` only → `flipX`=1; `moveRight` only → `flipX`=0; both or neither → hold. Frozen in HIT.
- States:
  - IDLE: `frameIdx`=0. SOF with latch set → HIT. SOF with `moving` → WALK, walk counter ← `FRAME_PERIOD-1`, `frameIdx` stays 0.
  - WALK: SOF with latch set → HIT (priority). SOF with not `moving` → IDLE, `frameIdx` ← 0. Otherwise, walk counter 0 → `frameIdx` ← (`frameIdx`+1) mod `NUM_FRAMES`, counter reloaded; else decrement.
  - HIT: on entry, blink counter ← `BLINK_FRAMES-1`, phase counter ← `BLINK_PERIOD-1`, `visible` ← 0, `hitActive` ← 1, `frameIdx` frozen. Each SOF: latch set → re-enter (full restart). Blink counter 0 → exit: `visible` ← 1, `hitActive` ← 0, next state WALK if `moving` (walk counter reloaded, `frameIdx` kept) else IDLE (`frameIdx` ← 0). Otherwise decrement blink counter; phase counter 0 → toggle `visible` and reload, else decrement.
- Counters sized by `$clog2` of their parameter; no wrap below 0 (reload always precedes).
- Mid-sequence reset returns everything to reset values immediately, regardless of state.

## Timing
- All outputs registered; they change on the SOF edge and are valid from the next cycle for the whole frame.
- Walk: first step on the 6th SOF after the entry SOF, then every 6 SOFs (defaults).
- HIT occupies exactly `BLINK_FRAMES` frames; `visible` low for the first `BLINK_PERIOD` frames.
- No input-to-output combinational path.

## Structure
- Package `sprite_anim_pkg`: state enum (IDLE, WALK, HIT), default parameter constants.
- Sub-module `frame_tick_counter`: loadable down-counter with `load`, `tick` (=SOF) and `zero` flag; instantiated for walk, blink and phase counters.
- FSM, hit latch and direction register remain in the top module.

## Test plan
- Reset asserted mid-HIT → same edge: `visible`=1, `hitActive`=0, `frameIdx`=0, `flipX`=0.
- `moveRight` held 25 SOFs from IDLE → `frameIdx` 1,2,3,0 on SOFs 7,13,19,25; `flipX`=0.
- `moveLeft` pulse between SOFs, then neither → `flipX` changes only at an SOF with `moveLeft` high; both high → `flipX` holds.
- `hit` pulse mid-frame while walking → next SOF: `hitActive`=1, `visible`=0; toggles at SOFs +4,+8,…,+20; exit at SOF +24 with `visible`=1, `frameIdx` unchanged if still moving.
- Second `hit` at SOF +10 of blink → restart: 24 more frames, `visible`=0 from that SOF.
- `freeze` held 10 frames while walking with `hit` pulse → no output change; on first unfrozen SOF, HIT entered.
